// File: rtl/wb_stage_pipe.sv
// Write-back stage: selects the register-file write source, waits for
// multi-cycle load / mul-div completion and extends load data.
module wb_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] pc4,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] pc_plus_imm,
    input  logic            ld,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic            jal,
    input  logic            jalr,
    input  logic            lui,
    input  logic            auipc,
    input  logic            md,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            md_valid,
    input  logic [XLEN-1:0] md_result,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy,
    output logic            timeout_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_MD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      alo_q, alo_d;
    logic            we_q, we_d;
    logic [RA_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            terr_q, terr_d;

    logic            accept;
    logic            hi_pri;
    logic            is_ld;
    logic            is_md;
    logic            tmo;
    logic [XLEN-1:0] imm_sel;
    logic [XLEN-1:0] ld_ext;
    logic [31:0]     word;
    logic [15:0]     half;
    logic [7:0]      byte_v;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == WAIT_MEM) || (state_q == WAIT_MD);
    assign accept   = in_valid && in_ready;
    // Any higher-priority flag masks ld/md entirely
    assign hi_pri   = lui || jal || jalr || auipc;
    assign is_ld    = !hi_pri && ld;
    assign is_md    = !hi_pri && !ld && md;
    assign tmo      = (cnt_q == CNT_LAST);

    assign rf_we       = we_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign timeout_err = terr_q;

    always_comb begin
        imm_sel = alu_out;
        if (lui)
            imm_sel = immediate;
        else if (jal || jalr)
            imm_sel = pc4;
        else if (auipc)
            imm_sel = pc_plus_imm;
    end

    always_comb begin
        word = mem_rdata[31:0];
        half = alo_q[1] ? word[31:16] : word[15:0];
        unique case (alo_q)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (f3_q)
            3'b000:  ld_ext = XLEN'($signed(byte_v));
            3'b100:  ld_ext = XLEN'(byte_v);
            3'b001:  ld_ext = XLEN'($signed(half));
            3'b101:  ld_ext = XLEN'(half);
            default: ld_ext = XLEN'($signed(word));
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            alo_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d  = rd_addr;
                    f3_d  = ld_funct3;
                    alo_d = ld_addr_lo;
                    cnt_d = '0;
                    if (is_ld)
                        state_d = WAIT_MEM;
                    else if (is_md)
                        state_d = WAIT_MD;
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid || tmo)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            WAIT_MD: begin
                if (md_valid || tmo)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes to x0 still update the data/address, only the strobe is masked
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !is_ld && !is_md) begin
                    waddr_d = rd_addr;
                    wdata_d = imm_sel;
                    we_d    = (rd_addr != '0);
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    waddr_d = rd_q;
                    wdata_d = ld_ext;
                    we_d    = (rd_q != '0);
                end else if (tmo) begin
                    terr_d = 1'b1;
                end
            end
            WAIT_MD: begin
                if (md_valid) begin
                    waddr_d = rd_q;
                    wdata_d = md_result;
                    we_d    = (rd_q != '0);
                end else if (tmo) begin
                    terr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: source select, load extension,
// waits, timeout, x0 masking and reset during a wait.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rd_addr;
    logic [31:0] alu_out, pc4, immediate, pc_plus_imm;
    logic        ld;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        jal, jalr, lui, auipc, md;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        md_valid;
    logic [31:0] md_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;
    int n;
    int bcnt;
    logic saw_we;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .RA_W(5), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd_addr(rd_addr), .alu_out(alu_out), .pc4(pc4),
        .immediate(immediate), .pc_plus_imm(pc_plus_imm),
        .ld(ld), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .jal(jal), .jalr(jalr), .lui(lui), .auipc(auipc), .md(md),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .md_valid(md_valid), .md_result(md_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 0; rd_addr = 0; alu_out = 0; pc4 = 0;
        immediate = 0; pc_plus_imm = 0; ld = 0; ld_funct3 = 0;
        ld_addr_lo = 0; jal = 0; jalr = 0; lui = 0; auipc = 0;
        md = 0; mem_rvalid = 0; mem_rdata = 0; md_valid = 0;
        md_result = 0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [1:0] alo, input logic [4:0] rd,
                           input logic [31:0] data, input logic [31:0] exp);
        in_valid = 1; ld = 1; ld_funct3 = f3; ld_addr_lo = alo;
        rd_addr = rd;
        step();
        clr();
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        repeat (2) step();
        mem_rvalid = 1; mem_rdata = data;
        step();
        clr();
        chk({tag, "_we"}, {31'b0, rf_we}, 32'd1);
        chk({tag, "_data"}, rf_wdata, exp);
        chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1;
        step();
        step();
        rst = 0;
        chk("rst_we", {31'b0, rf_we}, 32'd0);
        chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);

        // ALU write, 1-cycle latency, single-cycle strobe
        in_valid = 1; rd_addr = 5; alu_out = 32'h12345678;
        step();
        clr();
        chk("alu_we", {31'b0, rf_we}, 32'd1);
        chk("alu_waddr", {27'b0, rf_waddr}, 32'd5);
        chk("alu_wdata", rf_wdata, 32'h12345678);
        step();
        chk("alu_we_off", {31'b0, rf_we}, 32'd0);
        chk("alu_hold", rf_wdata, 32'h12345678);

        // lui masks ld
        in_valid = 1; lui = 1; ld = 1; immediate = 32'hABCDE000;
        rd_addr = 3; alu_out = 32'h0BAD0BAD;
        step();
        clr();
        chk("lui_we", {31'b0, rf_we}, 32'd1);
        chk("lui_waddr", {27'b0, rf_waddr}, 32'd3);
        chk("lui_wdata", rf_wdata, 32'hABCDE000);
        chk("lui_rdy", {31'b0, in_ready}, 32'd1);
        chk("lui_busy", {31'b0, busy}, 32'd0);

        // back-to-back: jal beats auipc, then auipc
        in_valid = 1; jal = 1; auipc = 1; pc4 = 32'h00001004;
        pc_plus_imm = 32'h00005000; rd_addr = 1;
        step();
        chk("b2b1_data", rf_wdata, 32'h00001004);
        chk("b2b1_we", {31'b0, rf_we}, 32'd1);
        jal = 0; rd_addr = 2;
        step();
        clr();
        chk("b2b2_data", rf_wdata, 32'h00005000);
        chk("b2b2_waddr", {27'b0, rf_waddr}, 32'd2);
        chk("b2b2_we", {31'b0, rf_we}, 32'd1);

        do_load("lb", 3'b000, 2'd2, 10, 32'h0080FF11, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 2'd2, 10, 32'h0080FF11, 32'h00000080);
        do_load("lh", 3'b001, 2'd2, 10, 32'h0080FF11, 32'h00000080);
        do_load("lhu", 3'b101, 2'd0, 10, 32'h0000FF11, 32'h0000FF11);
        do_load("lb1", 3'b000, 2'd1, 11, 32'h0080FF11, 32'hFFFFFFFF);
        do_load("lh0", 3'b001, 2'd0, 11, 32'h0080FF11, 32'hFFFFFF11);
        do_load("lw", 3'b010, 2'd0, 12, 32'h80000001, 32'h80000001);
        do_load("lbu3", 3'b100, 2'd3, 12, 32'hC3000000, 32'h000000C3);
        do_load("f3_111", 3'b111, 2'd0, 12, 32'h76543210, 32'h76543210);

        // mul/div wait of 33 cycles
        in_valid = 1; md = 1; rd_addr = 7;
        step();
        clr();
        bcnt = 0;
        for (int i = 1; i <= 33; i++) begin
            if (busy && !in_ready) bcnt++;
            if (i == 33) begin
                md_valid = 1; md_result = 32'hFFFFFFFE;
            end
            step();
        end
        clr();
        chk("md_busy_cycles", bcnt, 32'd33);
        chk("md_we", {31'b0, rf_we}, 32'd1);
        chk("md_waddr", {27'b0, rf_waddr}, 32'd7);
        chk("md_wdata", rf_wdata, 32'hFFFFFFFE);
        chk("md_rdy", {31'b0, in_ready}, 32'd1);

        // spurious valids in IDLE
        md_valid = 1; mem_rvalid = 1; md_result = 32'h1; mem_rdata = 32'h2;
        step();
        clr();
        chk("spur_we", {31'b0, rf_we}, 32'd0);
        chk("spur_busy", {31'b0, busy}, 32'd0);
        chk("spur_hold", rf_wdata, 32'hFFFFFFFE);

        // timeout on load
        in_valid = 1; ld = 1; ld_funct3 = 3'b010; rd_addr = 9;
        step();
        clr();
        n = 0;
        saw_we = 0;
        while (n < 300) begin
            step();
            n++;
            if (rf_we) saw_we = 1;
            if (timeout_err) break;
        end
        chk("tmo_cycles", n, 32'd255);
        chk("tmo_no_we", {31'b0, saw_we}, 32'd0);
        chk("tmo_rdy", {31'b0, in_ready}, 32'd1);
        chk("tmo_busy", {31'b0, busy}, 32'd0);
        step();
        chk("tmo_pulse", {31'b0, timeout_err}, 32'd0);

        // valid on the timeout cycle wins
        in_valid = 1; ld = 1; ld_funct3 = 3'b010; rd_addr = 10;
        step();
        clr();
        repeat (254) step();
        chk("tmo2_busy", {31'b0, busy}, 32'd1);
        mem_rvalid = 1; mem_rdata = 32'h11223344;
        step();
        clr();
        chk("tmo2_we", {31'b0, rf_we}, 32'd1);
        chk("tmo2_data", rf_wdata, 32'h11223344);
        chk("tmo2_terr", {31'b0, timeout_err}, 32'd0);
        step();
        chk("tmo2_terr2", {31'b0, timeout_err}, 32'd0);

        // jal to x0
        in_valid = 1; jal = 1; rd_addr = 0; pc4 = 32'h00000100;
        step();
        clr();
        chk("x0_we", {31'b0, rf_we}, 32'd0);
        chk("x0_wdata", rf_wdata, 32'h00000100);
        chk("x0_waddr", {27'b0, rf_waddr}, 32'd0);

        // reset during WAIT_MEM drops the write
        in_valid = 1; ld = 1; rd_addr = 4;
        step();
        clr();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rstw_busy", {31'b0, busy}, 32'd0);
        chk("rstw_rdy", {31'b0, in_ready}, 32'd1);
        chk("rstw_wdata", rf_wdata, 32'd0);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        step();
        clr();
        chk("rstw_we", {31'b0, rf_we}, 32'd0);
        chk("rstw_hold", rf_wdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered, parametrised write-back stage for the RV32IM core.
- Selects the register-file write value from these sources: ALU, load data, PC+4, immediate (LUI), PC+imm (AUIPC) and mul/div result.
- Waits for multi-cycle load and mul/div completion, and performs load byte/half extraction with sign or zero extension.
- Sits between the execute/memory stage and the register file. It applies back-pressure to the upstream stage through a valid/ready handshake.

Parameters:
- XLEN, 32, data width of all data ports. Must be at least 32.
- RA_W, 5, register address width.
- TIMEOUT, 255, maximum number of cycles spent waiting for mem/muldiv completion before the op is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept an op
- rd_addr  in  RA_W  destination register
- alu_out  in  XLEN  ALU result
- pc4  in  XLEN  PC+4
- immediate  in  XLEN  U-immediate, already shifted
- pc_plus_imm  in  XLEN  AUIPC result
- ld  in  1  load op
- ld_funct3  in  3  load type
- ld_addr_lo  in  2  load address bits [1:0]
- jal, jalr, lui, auipc, md  in  1 each  op flags
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  raw load word
- md_valid  in  1  mul/div result valid
- md_result  in  XLEN  mul/div result
- rf_we  out  1  register-file write strobe
- rf_waddr  out  RA_W  write address
- rf_wdata  out  XLEN  write data
- busy  out  1  stage is in a wait state
- timeout_err  out  1  one-cycle pulse when a wait is aborted

Behaviour:
- Reset values (synchronous, rst high at a clk edge):
  - state=IDLE, counter=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, timeout_err=0, busy=0.
  - in_ready=1 the cycle after reset.
  - Reset overrides any pending wait. The pending write is dropped.
- in_ready = (state==IDLE). An op is accepted when in_valid && in_ready.
- Source priority is fixed, highest first: lui > (jal|jalr) > auipc > ld > md > alu.
  - A higher flag masks the lower flags entirely. Example: lui=1 with ld=1 produces an immediate write and no wait.
- IDLE, accepting an immediate-class op (lui/jal/jalr/auipc/alu):
  - Next cycle: rf_we=1, rf_waddr=rd_addr, rf_wdata=selected source.
  - Latency is 1 cycle. Back-to-back accepts give back-to-back writes.
- IDLE, accepting a load: latch rd_addr, ld_funct3 and ld_addr_lo, then go to WAIT_MEM.
- IDLE, accepting an md op: latch rd_addr, then go to WAIT_MD.
- WAIT_MEM:
  - mem_rvalid is sampled only in this state. Its earliest effective cycle is the one after the accept.
  - On mem_rvalid: the next cycle gives rf_we=1 with the extended data, and the state returns to IDLE.
  - in_ready is high again in that same write cycle.
- WAIT_MD: same as WAIT_MEM, using md_valid and md_result unmodified.
- Load extension (from the lower 32 bits of mem_rdata):
  - 000 LB: byte selected by addr_lo, sign-extended to XLEN.
  - 100 LBU: byte selected by addr_lo, zero-extended.
  - 001 LH: half selected by addr_lo[1], sign-extended.
  - 101 LHU: half selected by addr_lo[1], zero-extended.
  - 010 LW: word, sign-extended to XLEN.
  - Other codes: treated as LW.
- Timeout:
  - counter clears on entry to a wait state and increments each wait cycle without valid.
  - When counter reaches TIMEOUT: timeout_err=1 for one cycle, rf_we stays 0, state returns to IDLE.
  - If valid and timeout occur in the same cycle, valid wins: normal write, no error.
- x0 protection: rf_we is forced to 0 when rf_waddr==0. rf_wdata is still updated.
- rf_we is a single-cycle pulse per completed op. When no op completes, rf_we=0 and rf_wdata/rf_waddr hold their last values.
- busy = (state==WAIT_MEM || state==WAIT_MD).
- Spurious mem_rvalid or md_valid while in IDLE is ignored.

Test Plan:
- Reset, then alu op with rd=5, alu_out=0x12345678 → one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x12345678. Next cycle rf_we=0.
- lui=1 and ld=1 together, immediate=0xABCDE000, rd=3 → 1-cycle write of 0xABCDE000. in_ready never drops.
- LB with addr_lo=2; 3 cycles later mem_rvalid with mem_rdata=0x0080FF11 → rf_wdata=0xFFFFFF80. Repeat as LBU → 0x00000080. LH with addr_lo=2, same data → 0x00000080. LHU with addr_lo=0, mem_rdata=0x0000FF11 → 0x0000FF11.
- md op, rd=7, md_valid after 33 cycles with md_result=0xFFFFFFFE → busy high for 33 cycles, then write 0xFFFFFFFE to r7. in_ready is low throughout the wait.
- Load with no mem_rvalid (TIMEOUT=255) → timeout_err pulses exactly once, after 255 wait cycles, with no rf_we. Then in_ready=1. Second run: mem_rvalid arrives on the timeout cycle → normal write, no error.
- jal with rd=0 → rf_we stays 0. Also: rst asserted mid WAIT_MEM and mem_rvalid arriving after release → no write, in_ready=1.
